serial_pattern_gen: RTL and testbench

//  Serial pattern transmitter: loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per clk.

---
 rtl/serial_pkg.sv | 12 +
 rtl/piso_shift.sv | 26 ++
 rtl/serial_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_serial_pattern_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encodings and default widths.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int PAT_W_DEF = 3;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register; sout is the next bit to be sent.
module piso_shift #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             sout
);

    logic [PAT_W-1:0] q;

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= {q[PAT_W-2:0], 1'b0};
    end

    assign sout = q[PAT_W-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: repeats a PAT_W-bit pattern MSB-first REPS times with idle gaps.
module serial_pattern_gen
    import serial_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_sof,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [REP_W-1:0] rep_cnt, rep_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [PAT_W-1:0] pat_q, ld_pat;
    logic [GAP_W-1:0] gap_q;
    logic             accept, load, shift, sr_next;
    logic             bo_n, vld_n, sof_n, busy_n, done_n;

    // The first bit goes straight into bit_out, so the shifter holds only the remaining bits.
    piso_shift #(.PAT_W(PAT_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   ({ld_pat[PAT_W-2:0], 1'b0}),
        .sout  (sr_next)
    );

    assign ld_pat = accept ? pattern : pat_q;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        rep_n   = rep_cnt;
        gap_n   = gap_cnt;
        accept  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        bo_n    = 1'b0;
        vld_n   = 1'b0;
        sof_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && reps != '0) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    bo_n    = pattern[PAT_W-1];
                    vld_n   = 1'b1;
                    sof_n   = 1'b1;
                    busy_n  = 1'b1;
                    idx_n   = LAST_IDX;
                    rep_n   = reps;
                    state_n = SEND;
                end else if (start) begin
                    done_n = 1'b1;
                end
            end
            SEND: begin
                busy_n = 1'b1;
                if (idx != '0) begin
                    shift = 1'b1;
                    bo_n  = sr_next;
                    vld_n = 1'b1;
                    idx_n = idx - 1'b1;
                end else if (rep_cnt > REP_W'(1)) begin
                    rep_n = rep_cnt - 1'b1;
                    if (gap_q != '0) begin
                        gap_n   = gap_q;
                        state_n = GAP;
                    end else begin
                        load  = 1'b1;
                        bo_n  = pat_q[PAT_W-1];
                        vld_n = 1'b1;
                        sof_n = 1'b1;
                        idx_n = LAST_IDX;
                    end
                end else begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            GAP: begin
                busy_n = 1'b1;
                // gap_cnt counts idle cycles still to show, including the current one
                if (gap_cnt == GAP_W'(1)) begin
                    load    = 1'b1;
                    bo_n    = pat_q[PAT_W-1];
                    vld_n   = 1'b1;
                    sof_n   = 1'b1;
                    idx_n   = LAST_IDX;
                    state_n = SEND;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            pat_q     <= '0;
            gap_q     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            frame_sof <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            rep_cnt   <= rep_n;
            gap_cnt   <= gap_n;
            if (accept) begin
                pat_q <= pattern;
                gap_q <= gap;
            end
            bit_out   <= bo_n;
            bit_valid <= vld_n;
            frame_sof <= sof_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen; each step checks {bit_out,bit_valid,frame_sof,busy,done}.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] pattern;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       bit_out, bit_valid, frame_sof, busy, done;

    int n_asserts = 0;
    int n_fail    = 0;

    serial_pattern_gen #(.PAT_W(3), .REP_W(4), .GAP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .reps      (reps),
        .gap       (gap),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .frame_sof (frame_sof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bit_out, bit_valid, frame_sof, busy, done};
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (bo,vld,sof,busy,done)", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample just after the edge.
    task automatic step(input string tag, input logic [4:0] exp);
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    task automatic go(input logic [2:0] p, input logic [3:0] r, input logic [3:0] g);
        pattern = p; reps = r; gap = g; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pattern = '0; reps = '0; gap = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset", 5'b00000);
        reset = 1'b0;
        step("idle", 5'b00000);

        // 110 once: bits on T+1..T+3, done at T+4
        go(3'b110, 4'd1, 4'd0);
        chk("t1_c1", 5'b11110);
        step("t1_c2", 5'b11010);
        step("t1_c3", 5'b01010);
        step("t1_done", 5'b00001);
        step("t1_idle", 5'b00000);

        // 101 x3 with a 2-cycle gap: 13 busy cycles
        go(3'b101, 4'd3, 4'd2);
        chk("t2_c1", 5'b11110);
        step("t2_c2", 5'b01010);
        step("t2_c3", 5'b11010);
        step("t2_c4", 5'b00010);
        step("t2_c5", 5'b00010);
        step("t2_c6", 5'b11110);
        step("t2_c7", 5'b01010);
        step("t2_c8", 5'b11010);
        step("t2_c9", 5'b00010);
        step("t2_c10", 5'b00010);
        step("t2_c11", 5'b11110);
        step("t2_c12", 5'b01010);
        step("t2_c13", 5'b11010);
        step("t2_done", 5'b00001);
        step("t2_idle", 5'b00000);

        // 110 x2 back-to-back
        go(3'b110, 4'd2, 4'd0);
        chk("t3_c1", 5'b11110);
        step("t3_c2", 5'b11010);
        step("t3_c3", 5'b01010);
        step("t3_c4", 5'b11110);
        step("t3_c5", 5'b11010);
        step("t3_c6", 5'b01010);
        step("t3_done", 5'b00001);
        step("t3_idle", 5'b00000);

        // reps=0: immediate done, never busy
        go(3'b111, 4'd0, 4'd3);
        chk("t4_done", 5'b00001);
        step("t4_idle", 5'b00000);

        // start held and inputs changed while busy; held start caught in the done cycle
        go(3'b101, 4'd1, 4'd0);
        chk("t5_c1", 5'b11110);
        start = 1'b1; pattern = 3'b010; reps = 4'd1; gap = 4'd5;
        step("t5_c2", 5'b01010);
        step("t5_c3", 5'b11010);
        step("t5_done", 5'b00001);
        step("t5_b2b_c1", 5'b01110);
        start = 1'b0; pattern = 3'b111;
        step("t5_b2b_c2", 5'b11010);
        step("t5_b2b_c3", 5'b01010);
        step("t5_b2b_done", 5'b00001);
        step("t5_idle", 5'b00000);

        // reset during the second bit of a 3-rep job, then a fresh job
        go(3'b110, 4'd3, 4'd1);
        chk("t6_c1", 5'b11110);
        step("t6_c2", 5'b11010);
        reset = 1'b1;
        step("t6_rst", 5'b00000);
        reset = 1'b0;
        step("t6_no_done", 5'b00000);
        step("t6_quiet", 5'b00000);
        go(3'b011, 4'd1, 4'd0);
        chk("t6_new_c1", 5'b01110);
        step("t6_new_c2", 5'b11010);
        step("t6_new_c3", 5'b11010);
        step("t6_new_done", 5'b00001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
